dcache_ctrl: RTL and testbench
==============================

Name: dcache_ctrl

Overview:
- Sequences the 2-way data cache array for the LSQ and shares it between one load requester and one store requester.
- Grants requesters round-robin and drives lookups into the array.
- On a miss: writes back a dirty victim, issues the line fill to memory, and tracks the memory tag until the fill returns.
- Sits between LSQ load/store ports, the dcache array and the mem.v bus interface; one request in flight at a time.

Parameters:
INDEX_W, 5, cache index bits (32 sets)
TAG_W, 8, tag bits; address = {tag, index, 3'b000}
ADDR_W, 16, byte address width = TAG_W+INDEX_W+3
BLK_W, 64, cache block / data width

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
ld_req_valid  in  1  load request
ld_req_addr  in  ADDR_W  load address
ld_req_ready  out  1  load accepted this cycle
ld_resp_valid  out  1  one-cycle pulse, load data valid
ld_resp_data  out  BLK_W  load data
st_req_valid  in  1  store request
st_req_addr  in  ADDR_W  store address
st_req_data  in  BLK_W  store block data
st_req_ready  out  1  store accepted this cycle
st_done  out  1  one-cycle pulse, store committed to cache
dc_index  out  INDEX_W  array index
dc_tag  out  TAG_W  array tag
dc_read_enable  out  1  array read
dc_write_enable  out  1  array write
dc_write_data  out  BLK_W  array write data
dc_mem_response  out  4  response tag forwarded to array
dc_mem_tag  out  4  completion tag forwarded to array
dc_data_is_valid  in  1  hit
dc_data_is_dirty  in  1  victim dirty
dc_data_is_miss  in  1  miss
dc_data_out  in  BLK_W  registered array read data (1-cycle latency)
dc_store_data  in  BLK_W  victim block
dc_victim_tag  in  TAG_W  victim tag
proc2mem_command  out  2  0 NONE, 1 LOAD, 2 STORE
proc2mem_addr  out  ADDR_W  memory address
proc2mem_data  out  BLK_W  writeback data
mem2proc_response  in  4  nonzero = accepted, value = transaction tag
mem2proc_tag  in  4  nonzero = completing transaction
miss_count  out  16  saturating miss counter

Behaviour:
- Reset: state IDLE; all outputs 0; latched address/data/pending tag 0; round-robin pointer = load; miss_count 0. Reset in any state abandons the request with no response pulse. Memory replies arriving after reset are ignored, because the pending tag is 0.
- dc_mem_tag = mem2proc_tag every cycle except under reset, where it is 0. dc_mem_response = 0 except as stated in FILL_REQ.
- dc_index/dc_tag/dc_write_data are driven from the latched request outside IDLE.
- IDLE:
  - If exactly one valid, grant it. If both are valid, grant the one not granted last, then flip the pointer.
  - Granted *_req_ready = 1 in that same cycle; latch address, data and type; go LOOKUP. Otherwise stay.
- LOOKUP (1 cycle):
  - Assert dc_read_enable for a load, or dc_write_enable for a store.
  - Load hit: go RESP.
  - Store hit: st_done = 1 this cycle; go IDLE.
  - Miss: miss_count += 1, saturating at 16'hFFFF.
    - dc_data_is_dirty = 1: latch dc_store_data and dc_victim_tag; go WRITEBACK.
    - Otherwise: go FILL_REQ.
- WRITEBACK:
  - proc2mem_command = STORE, proc2mem_addr = {victim_tag, index, 3'b0}, proc2mem_data = victim block.
  - Hold until mem2proc_response != 0, then go FILL_REQ.
- FILL_REQ:
  - proc2mem_command = LOAD, proc2mem_addr = latched address.
  - Re-assert the request's dc_read_enable / dc_write_enable, with dc_mem_response = mem2proc_response so the array records the pending tag.
  - Stay while response == 0. On nonzero response, latch it as the pending tag and go FILL_WAIT.
- FILL_WAIT:
  - Idle outputs; wait for mem2proc_tag == pending tag (nonzero).
  - In the match cycle, dc_write_data carries the latched store data, and the array fills.
  - Load: go RESP. Store: st_done = 1 in that cycle; go IDLE.
  - Tags of other transactions are forwarded but otherwise ignored.
- RESP (1 cycle): ld_resp_valid = 1, ld_resp_data = dc_data_out; go IDLE.
- Requests are never accepted outside IDLE; *_req_ready = 0 there.
- Load-hit latency: request to ld_resp_valid = 2 cycles.

Test Plan:
- Load hit: preload set 3 tag 8'h12; ld_req addr 16'h1218 -> ld_req_ready cycle 0, dc_read_enable cycle 1, ld_resp_valid cycle 2 with preload data; miss_count 0.
- Clean store miss: st_req addr 16'h3400, data 64'hDEAD -> LOOKUP miss, LOAD issued; mem response 4'h5 forwarded on dc_mem_response; tag 4'h5 returns 3 cycles later -> st_done that cycle; miss_count 1.
- Dirty load miss: victim tag 8'hAA, index 0 dirty -> STORE to 16'hAA00 with victim data held through 2 zero-response cycles, then LOAD; fill with tag 4'h3 -> ld_resp_valid next cycle with fill data.
- Arbitration: ld and st valid every cycle -> grants alternate load, store, load, store; no request is granted twice in a row while the other is pending.
- Foreign tag: in FILL_WAIT pending 4'h7, mem2proc_tag 4'h2 -> no completion, state held; 4'h7 -> completion.
- Reset mid-FILL_WAIT -> outputs 0, IDLE; later mem2proc_tag 4'h7 -> no ld_resp_valid or st_done.

Source files
------------

// File: rtl/dcache_ctrl.sv
// Data cache controller: arbitrates one load and one store requester onto the 2-way array,
// sequencing lookup, dirty-victim writeback, line fill and load response, one request at a time.
module dcache_ctrl #(
  parameter int INDEX_W = 5,
  parameter int TAG_W   = 8,
  parameter int ADDR_W  = 16,
  parameter int BLK_W   = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ld_req_valid,
  input  logic [ADDR_W-1:0] ld_req_addr,
  output logic              ld_req_ready,
  output logic              ld_resp_valid,
  output logic [BLK_W-1:0]  ld_resp_data,
  input  logic              st_req_valid,
  input  logic [ADDR_W-1:0] st_req_addr,
  input  logic [BLK_W-1:0]  st_req_data,
  output logic              st_req_ready,
  output logic              st_done,
  output logic [INDEX_W-1:0] dc_index,
  output logic [TAG_W-1:0]  dc_tag,
  output logic              dc_read_enable,
  output logic              dc_write_enable,
  output logic [BLK_W-1:0]  dc_write_data,
  output logic [3:0]        dc_mem_response,
  output logic [3:0]        dc_mem_tag,
  input  logic              dc_data_is_valid,
  input  logic              dc_data_is_dirty,
  input  logic              dc_data_is_miss,
  input  logic [BLK_W-1:0]  dc_data_out,
  input  logic [BLK_W-1:0]  dc_store_data,
  input  logic [TAG_W-1:0]  dc_victim_tag,
  output logic [1:0]        proc2mem_command,
  output logic [ADDR_W-1:0] proc2mem_addr,
  output logic [BLK_W-1:0]  proc2mem_data,
  input  logic [3:0]        mem2proc_response,
  input  logic [3:0]        mem2proc_tag,
  output logic [15:0]       miss_count
);

  localparam logic [1:0] CMD_NONE  = 2'd0;
  localparam logic [1:0] CMD_LOAD  = 2'd1;
  localparam logic [1:0] CMD_STORE = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WRITEBACK,
    S_FILL_REQ,
    S_FILL_WAIT,
    S_RESP
  } state_t;

  state_t             state_q, state_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [BLK_W-1:0]   data_q, data_d;
  logic               is_store_q, is_store_d;
  logic [BLK_W-1:0]   victim_data_q, victim_data_d;
  logic [TAG_W-1:0]   victim_tag_q, victim_tag_d;
  logic [3:0]         pend_tag_q, pend_tag_d;
  logic               rr_store_q, rr_store_d;  // 1: store wins the next contended cycle
  logic [15:0]        miss_count_q, miss_count_d;

  logic               grant_ld, grant_st, hit, fill_done;
  logic [INDEX_W-1:0] req_index;
  logic [TAG_W-1:0]   req_tag;

  assign req_index = addr_q[INDEX_W+2:3];
  assign req_tag   = addr_q[ADDR_W-1 -: TAG_W];

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      data_q        <= '0;
      is_store_q    <= 1'b0;
      victim_data_q <= '0;
      victim_tag_q  <= '0;
      pend_tag_q    <= '0;
      rr_store_q    <= 1'b0;
      miss_count_q  <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      data_q        <= data_d;
      is_store_q    <= is_store_d;
      victim_data_q <= victim_data_d;
      victim_tag_q  <= victim_tag_d;
      pend_tag_q    <= pend_tag_d;
      rr_store_q    <= rr_store_d;
      miss_count_q  <= miss_count_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    data_d        = data_q;
    is_store_d    = is_store_q;
    victim_data_d = victim_data_q;
    victim_tag_d  = victim_tag_q;
    pend_tag_d    = pend_tag_q;
    rr_store_d    = rr_store_q;
    miss_count_d  = miss_count_q;

    ld_req_ready     = 1'b0;
    ld_resp_valid    = 1'b0;
    ld_resp_data     = '0;
    st_req_ready     = 1'b0;
    st_done          = 1'b0;
    dc_index         = '0;
    dc_tag           = '0;
    dc_read_enable   = 1'b0;
    dc_write_enable  = 1'b0;
    dc_write_data    = '0;
    dc_mem_response  = '0;
    dc_mem_tag       = '0;
    proc2mem_command = CMD_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = '0;
    miss_count       = '0;

    grant_ld  = 1'b0;
    grant_st  = 1'b0;
    hit       = dc_data_is_valid && !dc_data_is_miss;
    // A zero pending tag never matches, so stale replies after reset are dropped.
    fill_done = (pend_tag_q != 4'd0) && (mem2proc_tag == pend_tag_q);

    if (!reset) begin
      dc_mem_tag = mem2proc_tag;
      miss_count = miss_count_q;
      if (state_q != S_IDLE) begin
        dc_index      = req_index;
        dc_tag        = req_tag;
        dc_write_data = data_q;
      end

      case (state_q)
        S_IDLE: begin
          if (ld_req_valid && st_req_valid) begin
            grant_st   = rr_store_q;
            grant_ld   = !rr_store_q;
            rr_store_d = !rr_store_q;
          end else begin
            grant_ld = ld_req_valid;
            grant_st = st_req_valid;
          end
          ld_req_ready = grant_ld;
          st_req_ready = grant_st;
          if (grant_ld || grant_st) begin
            addr_d     = grant_st ? st_req_addr : ld_req_addr;
            data_d     = grant_st ? st_req_data : '0;
            is_store_d = grant_st;
            state_d    = S_LOOKUP;
          end
        end

        S_LOOKUP: begin
          dc_read_enable  = !is_store_q;
          dc_write_enable = is_store_q;
          if (hit) begin
            if (is_store_q) begin
              st_done = 1'b1;
              state_d = S_IDLE;
            end else begin
              state_d = S_RESP;
            end
          end else begin
            if (miss_count_q != 16'hFFFF) miss_count_d = miss_count_q + 16'd1;
            if (dc_data_is_dirty) begin
              victim_data_d = dc_store_data;
              victim_tag_d  = dc_victim_tag;
              state_d       = S_WRITEBACK;
            end else begin
              state_d = S_FILL_REQ;
            end
          end
        end

        S_WRITEBACK: begin
          proc2mem_command = CMD_STORE;
          proc2mem_addr    = {victim_tag_q, req_index, 3'b000};
          proc2mem_data    = victim_data_q;
          if (mem2proc_response != 4'd0) state_d = S_FILL_REQ;
        end

        S_FILL_REQ: begin
          proc2mem_command = CMD_LOAD;
          proc2mem_addr    = addr_q;
          dc_read_enable   = !is_store_q;
          dc_write_enable  = is_store_q;
          dc_mem_response  = mem2proc_response;
          if (mem2proc_response != 4'd0) begin
            pend_tag_d = mem2proc_response;
            state_d    = S_FILL_WAIT;
          end
        end

        S_FILL_WAIT: begin
          if (fill_done) begin
            pend_tag_d = '0;
            if (is_store_q) begin
              st_done = 1'b1;
              state_d = S_IDLE;
            end else begin
              state_d = S_RESP;
            end
          end
        end

        S_RESP: begin
          ld_resp_valid = 1'b1;
          ld_resp_data  = dc_data_out;
          state_d       = S_IDLE;
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed bench for dcache_ctrl: each cycle's expected outputs come from the request/miss
// rules, and a negedge compare process checks every output against them.
module tb_dcache_ctrl;
  logic        clock = 1'b0;
  logic        reset;
  logic        ld_req_valid, st_req_valid;
  logic [15:0] ld_req_addr, st_req_addr;
  logic [63:0] st_req_data;
  logic        ld_req_ready, ld_resp_valid, st_req_ready, st_done;
  logic [63:0] ld_resp_data;
  logic [4:0]  dc_index;
  logic [7:0]  dc_tag;
  logic        dc_read_enable, dc_write_enable;
  logic [63:0] dc_write_data;
  logic [3:0]  dc_mem_response, dc_mem_tag;
  logic        dc_data_is_valid, dc_data_is_dirty, dc_data_is_miss;
  logic [63:0] dc_data_out, dc_store_data;
  logic [7:0]  dc_victim_tag;
  logic [1:0]  proc2mem_command;
  logic [15:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  logic [3:0]  mem2proc_response, mem2proc_tag;
  logic [15:0] miss_count;

  always #5 clock = ~clock;

  dcache_ctrl dut (
    .clock(clock), .reset(reset),
    .ld_req_valid(ld_req_valid), .ld_req_addr(ld_req_addr), .ld_req_ready(ld_req_ready),
    .ld_resp_valid(ld_resp_valid), .ld_resp_data(ld_resp_data),
    .st_req_valid(st_req_valid), .st_req_addr(st_req_addr), .st_req_data(st_req_data),
    .st_req_ready(st_req_ready), .st_done(st_done),
    .dc_index(dc_index), .dc_tag(dc_tag), .dc_read_enable(dc_read_enable),
    .dc_write_enable(dc_write_enable), .dc_write_data(dc_write_data),
    .dc_mem_response(dc_mem_response), .dc_mem_tag(dc_mem_tag),
    .dc_data_is_valid(dc_data_is_valid), .dc_data_is_dirty(dc_data_is_dirty),
    .dc_data_is_miss(dc_data_is_miss), .dc_data_out(dc_data_out),
    .dc_store_data(dc_store_data), .dc_victim_tag(dc_victim_tag),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_data(proc2mem_data), .mem2proc_response(mem2proc_response),
    .mem2proc_tag(mem2proc_tag), .miss_count(miss_count)
  );

  int chk_cnt = 0;
  int pass_cnt = 0;
  logic chk_en = 1'b0;

  // Model state: the request currently owning the array and the number of misses seen.
  logic        busy = 1'b0;
  logic [15:0] cur_addr = '0;
  logic [63:0] cur_data = '0;
  int          exp_miss = 0;

  logic        e_ld_ready, e_st_ready, e_ld_resp, e_st_done, e_rd, e_wr;
  logic [63:0] e_ld_data, e_p2m_data;
  logic [3:0]  e_resp;
  logic [1:0]  e_cmd;
  logic [15:0] e_p2m_addr;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
  endtask

  function automatic logic [15:0] mk_addr(input logic [7:0] tag, input logic [4:0] idx);
    return {tag, idx, 3'b000};
  endfunction

  always @(negedge clock) begin : compare
    logic [15:0] em;
    logic        own;
    if (chk_en) begin
      em  = reset ? 16'd0 : ((exp_miss > 65535) ? 16'hFFFF : 16'(exp_miss));
      own = busy && !reset;
      chk("ld_req_ready", ld_req_ready, e_ld_ready);
      chk("st_req_ready", st_req_ready, e_st_ready);
      chk("ld_resp_valid", ld_resp_valid, e_ld_resp);
      chk("ld_resp_data", ld_resp_data, e_ld_resp ? e_ld_data : 64'd0);
      chk("st_done", st_done, e_st_done);
      chk("dc_read_enable", dc_read_enable, e_rd);
      chk("dc_write_enable", dc_write_enable, e_wr);
      chk("dc_index", dc_index, own ? cur_addr[7:3] : 5'd0);
      chk("dc_tag", dc_tag, own ? cur_addr[15:8] : 8'd0);
      chk("dc_write_data", dc_write_data, own ? cur_data : 64'd0);
      chk("dc_mem_response", dc_mem_response, e_resp);
      chk("dc_mem_tag", dc_mem_tag, reset ? 4'd0 : mem2proc_tag);
      chk("proc2mem_command", proc2mem_command, e_cmd);
      chk("proc2mem_addr", proc2mem_addr, e_p2m_addr);
      chk("proc2mem_data", proc2mem_data, e_p2m_data);
      chk("miss_count", miss_count, em);
    end
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
    ld_req_valid = 0; st_req_valid = 0;
    dc_data_is_valid = 0; dc_data_is_dirty = 0; dc_data_is_miss = 0;
    mem2proc_response = 0; mem2proc_tag = 0;
    e_ld_ready = 0; e_st_ready = 0; e_ld_resp = 0; e_st_done = 0; e_rd = 0; e_wr = 0;
    e_ld_data = 0; e_p2m_data = 0; e_resp = 0; e_cmd = 0; e_p2m_addr = 0;
  endtask

  task automatic both_valid();
    ld_req_valid = 1; st_req_valid = 1;
    ld_req_addr = 16'h2010; st_req_addr = 16'h3028; st_req_data = 64'd0;
    dc_data_is_valid = 1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    logic [3:0] seq;
    logic       due_st, is_st;
    reset = 1;
    ld_req_addr = 0; st_req_addr = 0; st_req_data = 0;
    dc_data_out = 0; dc_store_data = 0; dc_victim_tag = 0;
    next_cycle();
    chk_en = 1;
    mem2proc_tag = 4'h9;  // must not be forwarded while in reset
    next_cycle();
    reset = 0;
    next_cycle();

    // Load hit: set 3, tag 8'h12
    next_cycle(); ld_req_valid = 1; ld_req_addr = 16'h1218; e_ld_ready = 1;
    next_cycle(); busy = 1; cur_addr = 16'h1218; cur_data = 0; dc_data_is_valid = 1; e_rd = 1;
    @(negedge clock); chk("lit_hit_index", dc_index, 5'd3); chk("lit_hit_tag", dc_tag, 8'h12);
    next_cycle(); dc_data_out = 64'hCAFE_F00D_1234_5678; e_ld_resp = 1; e_ld_data = dc_data_out;
    @(negedge clock); chk("lit_hit_data", ld_resp_data, 64'hCAFE_F00D_1234_5678);
    next_cycle(); busy = 0;
    @(negedge clock); chk("lit_miss_after_hit", miss_count, 16'd0);
    $display("txn load-hit addr=1218 data=%h", ld_resp_data);

    // Clean store miss, memory tag 5 returns three cycles after acceptance
    next_cycle(); st_req_valid = 1; st_req_addr = 16'h3400; st_req_data = 64'hDEAD; e_st_ready = 1;
    next_cycle(); busy = 1; cur_addr = 16'h3400; cur_data = 64'hDEAD; dc_data_is_miss = 1; e_wr = 1;
    next_cycle(); exp_miss++; mem2proc_response = 4'h5;
    e_cmd = 2'd1; e_p2m_addr = cur_addr; e_wr = 1; e_resp = 4'h5;
    @(negedge clock); chk("lit_fwd_resp", dc_mem_response, 4'h5);
    next_cycle();
    next_cycle();
    next_cycle(); mem2proc_tag = 4'h5; e_st_done = 1;
    next_cycle(); busy = 0;
    @(negedge clock); chk("lit_miss_store", miss_count, 16'd1);
    $display("txn store-miss addr=3400 misses=%0d", miss_count);

    // Dirty load miss: victim tag AA at index 0, writeback held two cycles
    next_cycle(); ld_req_valid = 1; ld_req_addr = 16'h5500; e_ld_ready = 1;
    next_cycle(); busy = 1; cur_addr = 16'h5500; cur_data = 0;
    dc_data_is_miss = 1; dc_data_is_dirty = 1;
    dc_store_data = 64'h0123_4567_89AB_CDEF; dc_victim_tag = 8'hAA; e_rd = 1;
    for (int c = 0; c < 3; c++) begin
      next_cycle();
      if (c == 0) exp_miss++;
      dc_store_data = 64'hFFFF_0000_FFFF_0000; dc_victim_tag = 8'h11;
      mem2proc_response = (c == 2) ? 4'h1 : 4'h0;
      e_cmd = 2'd2; e_p2m_addr = mk_addr(8'hAA, cur_addr[7:3]);
      e_p2m_data = 64'h0123_4567_89AB_CDEF;
      @(negedge clock); chk("lit_wb_addr", proc2mem_addr, 16'hAA00);
    end
    next_cycle(); e_cmd = 2'd1; e_p2m_addr = cur_addr; e_rd = 1;
    next_cycle(); mem2proc_response = 4'h3; e_cmd = 2'd1; e_p2m_addr = cur_addr; e_rd = 1; e_resp = 4'h3;
    next_cycle();
    next_cycle(); mem2proc_tag = 4'h3;
    next_cycle(); dc_data_out = 64'hF111_2222_3333_4444; e_ld_resp = 1; e_ld_data = dc_data_out;
    next_cycle(); busy = 0;
    @(negedge clock); chk("lit_miss_dirty", miss_count, 16'd2);
    $display("txn dirty-load-miss addr=5500 victim=AA00 misses=%0d", miss_count);

    // Foreign tag while pending tag 7 is outstanding
    next_cycle(); ld_req_valid = 1; ld_req_addr = 16'h0808; e_ld_ready = 1;
    next_cycle(); busy = 1; cur_addr = 16'h0808; cur_data = 0; dc_data_is_miss = 1; e_rd = 1;
    next_cycle(); exp_miss++; mem2proc_response = 4'h7;
    e_cmd = 2'd1; e_p2m_addr = cur_addr; e_rd = 1; e_resp = 4'h7;
    next_cycle(); mem2proc_tag = 4'h2;
    next_cycle();
    next_cycle(); mem2proc_tag = 4'h7;
    next_cycle(); dc_data_out = 64'h7777_0000_7777_0000; e_ld_resp = 1; e_ld_data = dc_data_out;
    next_cycle(); busy = 0;
    $display("txn foreign-tag addr=0808 misses=%0d", miss_count);

    // Reset while a store waits on tag 7; the late reply must be ignored
    next_cycle(); st_req_valid = 1; st_req_addr = 16'h4110; st_req_data = 64'hBEEF; e_st_ready = 1;
    next_cycle(); busy = 1; cur_addr = 16'h4110; cur_data = 64'hBEEF; dc_data_is_miss = 1; e_wr = 1;
    next_cycle(); exp_miss++; mem2proc_response = 4'h7;
    e_cmd = 2'd1; e_p2m_addr = cur_addr; e_wr = 1; e_resp = 4'h7;
    next_cycle();
    next_cycle(); reset = 1; mem2proc_tag = 4'h7; busy = 0; exp_miss = 0;
    @(negedge clock); chk("lit_reset_tag", dc_mem_tag, 4'h0);
    next_cycle(); reset = 0; mem2proc_tag = 4'h7;
    next_cycle(); mem2proc_tag = 4'h7;
    next_cycle();
    @(negedge clock); chk("lit_miss_reset", miss_count, 16'd0);
    $display("txn reset-in-fill-wait misses=%0d", miss_count);

    // Contention: both requesters valid every cycle, pointer starts at load after reset
    due_st = 1'b0;
    seq = '0;
    for (int g = 0; g < 4; g++) begin
      next_cycle(); both_valid(); busy = 0;
      is_st = due_st; due_st = !due_st;
      e_ld_ready = !is_st; e_st_ready = is_st;
      @(negedge clock); seq[g] = st_req_ready;
      next_cycle(); both_valid(); busy = 1;
      cur_addr = is_st ? 16'h3028 : 16'h2010; cur_data = 0;
      if (is_st) begin e_wr = 1; e_st_done = 1; end
      else e_rd = 1;
      if (!is_st) begin
        next_cycle(); both_valid();
        dc_data_out = 64'hA5A5_0000_0000_0000 + 64'(g);
        e_ld_resp = 1; e_ld_data = dc_data_out;
      end
      $display("txn arb grant %0d -> %s", g, is_st ? "store" : "load");
    end
    next_cycle(); busy = 0;
    chk("lit_arb_order", seq, 4'b1010);

    next_cycle();
    chk_en = 0;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
